mips_multicycle_ctrl: RTL and testbench

Multi-cycle MIPS control unit; sits directly upstream of the Alu and drives its 4-bit op plus all datapath enables/muxes. Decodes opcode/funct from the instruction register, sequences FETCH→DECODE→execute states, and consumes the ALU zero flag for branches. Memory accesses use a mem_ready handshake so slow memory stalls the FSM.

---
 rtl/mips_pkg.sv | 42 ++++
 rtl/alu_decoder.sv | 24 ++
 rtl/mips_multicycle_ctrl.sv | 173 +++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, functs,
// Alu op codes and controller state encoding.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMRD    = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWR    = 4'd5,
    ST_RTYPE_EX = 4'd6,
    ST_ALUWB    = 4'd7,
    ST_BEQ      = 4'd8,
    ST_ADDI_EX  = 4'd9,
    ST_ADDI_WB  = 4'd10,
    ST_JUMP     = 4'd11,
    ST_TRAP     = 4'd12
  } state_e;

endpackage

// File: rtl/alu_decoder.sv
// R-type funct to Alu op translation; legal flags the six supported functs.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       legal
);

  always_comb begin
    alu_op = ALU_ADD;
    legal  = 1'b1;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_NOR:  alu_op = ALU_NOR;
      FN_SLT:  alu_op = ALU_SLT;
      default: legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control unit: Moore sequencer driving datapath enables,
// mux selects and the Alu op, with mem_ready stalls on memory states.
//
// state    | meaning
// FETCH    | read instruction at PC, PC+4 into PC on mem_ready
// DECODE   | compute branch target, dispatch on opcode/funct
// MEMADR   | A + sign-ext imm -> ALUOut
// MEMRD    | read data memory at ALUOut until mem_ready
// MEMWB    | MDR -> rt
// MEMWR    | write data memory at ALUOut until mem_ready
// RTYPE_EX | A op B
// ALUWB    | ALUOut -> rd
// BEQ      | A - B, take ALUOut as PC when zero
// ADDI_EX  | A + sign-ext imm
// ADDI_WB  | ALUOut -> rt
// JUMP     | jump target -> PC
// TRAP     | illegal instruction, parked until reset
module mips_multicycle_ctrl
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       trap
);

  state_e     state_q, state_d;
  logic [3:0] rtype_op;
  logic       rtype_legal;

  alu_decoder u_alu_decoder (
    .funct  (funct),
    .alu_op (rtype_op),
    .legal  (rtype_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_RTYPE:     state_d = rtype_legal ? ST_RTYPE_EX : ST_TRAP;
          OP_BEQ:       state_d = ST_BEQ;
          OP_ADDI:      state_d = ST_ADDI_EX;
          OP_J:         state_d = ST_JUMP;
          default:      state_d = ST_TRAP;
        endcase
      end
      ST_MEMADR:   state_d = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD:    if (mem_ready) state_d = ST_MEMWB;
      ST_MEMWB:    state_d = ST_FETCH;
      ST_MEMWR:    if (mem_ready) state_d = ST_FETCH;
      ST_RTYPE_EX: state_d = ST_ALUWB;
      ST_ALUWB:    state_d = ST_FETCH;
      ST_BEQ:      state_d = ST_FETCH;
      ST_ADDI_EX:  state_d = ST_ADDI_WB;
      ST_ADDI_WB:  state_d = ST_FETCH;
      ST_JUMP:     state_d = ST_FETCH;
      ST_TRAP:     state_d = ST_TRAP;
      default:     state_d = ST_FETCH;
    endcase
  end

  // Reset gating is combinational so strobes drop the moment rst_n falls.
  always_comb begin
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = ALU_AND;
    pc_source  = 2'b00;
    instr_done = 1'b0;
    trap       = 1'b0;
    if (!rst_n) begin
      alu_op = ALU_ADD;
    end else begin
      case (state_q)
        ST_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          alu_op    = ALU_ADD;
          ir_write  = mem_ready;
          pc_en     = mem_ready;
        end
        ST_DECODE: begin
          alu_src_b = 2'b11;
          alu_op    = ALU_ADD;
        end
        ST_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = ALU_ADD;
        end
        ST_MEMRD: begin
          iord     = 1'b1;
          mem_read = 1'b1;
        end
        ST_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        ST_MEMWR: begin
          iord       = 1'b1;
          mem_write  = 1'b1;
          instr_done = mem_ready;
        end
        ST_RTYPE_EX: begin
          alu_src_a = 1'b1;
          alu_op    = rtype_op;
        end
        ST_ALUWB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
        end
        ST_BEQ: begin
          alu_src_a  = 1'b1;
          alu_op     = ALU_SUB;
          pc_source  = 2'b01;
          pc_en      = zero;
          instr_done = 1'b1;
        end
        ST_ADDI_EX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = ALU_ADD;
        end
        ST_ADDI_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        ST_JUMP: begin
          pc_source  = 2'b10;
          pc_en      = 1'b1;
          instr_done = 1'b1;
        end
        ST_TRAP: trap = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-cycle output vectors and instruction
// latencies checked against a phase-sequence reference model.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg;
  logic       reg_write, alu_src_a, instr_done, trap;
  logic [1:0] alu_src_b, pc_source;
  logic [3:0] alu_op;
  logic [18:0] obs;

  int checks = 0;
  int failures = 0;

  localparam int P_RESET = 0, P_FETCH = 1, P_DECODE = 2, P_MEMADR = 3, P_MEMRD = 4,
                 P_MEMWB = 5, P_MEMWR = 6, P_REX = 7, P_ALUWB = 8, P_BEQ = 9,
                 P_AEX = 10, P_AWB = 11, P_JUMP = 12, P_TRAP = 13;

  logic [5:0] fns [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
  logic [5:0] ops [5] = '{6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};

  int ph_q[$];
  bit mr_q[$];

  mips_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .instr_done(instr_done), .trap(trap)
  );

  always #5 clk = ~clk;

  assign obs = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done, trap};

  function automatic logic [3:0] fn_op(logic [5:0] f);
    case (f)
      6'h20: return 4'd2;
      6'h22: return 4'd6;
      6'h24: return 4'd0;
      6'h25: return 4'd1;
      6'h27: return 4'd12;
      6'h2A: return 4'd7;
      default: return 4'hx;
    endcase
  endfunction

  function automatic int base_latency(logic [5:0] op);
    case (op)
      6'h00: return 4;
      6'h08: return 4;
      6'h04: return 3;
      6'h02: return 3;
      6'h23: return 5;
      6'h2B: return 4;
      default: return -1;
    endcase
  endfunction

  function automatic logic [18:0] expect_out(int ph, logic z, logic mr, logic [5:0] f);
    logic pe = 0, io = 0, mrd = 0, mwr = 0, irw = 0, rd = 0, m2r = 0, rw = 0, sa = 0;
    logic [1:0] sb = 0, ps = 0;
    logic [3:0] op = 0;
    logic dn = 0, tr = 0;
    case (ph)
      P_RESET:  op = 4'd2;
      P_FETCH:  begin mrd = 1; sb = 2'b01; op = 4'd2; irw = mr; pe = mr; end
      P_DECODE: begin sb = 2'b11; op = 4'd2; end
      P_MEMADR: begin sa = 1; sb = 2'b10; op = 4'd2; end
      P_MEMRD:  begin io = 1; mrd = 1; end
      P_MEMWB:  begin rw = 1; m2r = 1; dn = 1; end
      P_MEMWR:  begin io = 1; mwr = 1; dn = mr; end
      P_REX:    begin sa = 1; op = fn_op(f); end
      P_ALUWB:  begin rw = 1; rd = 1; dn = 1; end
      P_BEQ:    begin sa = 1; op = 4'd6; ps = 2'b01; pe = z; dn = 1; end
      P_AEX:    begin sa = 1; sb = 2'b10; op = 4'd2; end
      P_AWB:    begin rw = 1; dn = 1; end
      P_JUMP:   begin ps = 2'b10; pe = 1; dn = 1; end
      P_TRAP:   tr = 1;
      default:  ;
    endcase
    return {pe, io, mrd, mwr, irw, rd, m2r, rw, sa, sb, op, ps, dn, tr};
  endfunction

  task automatic chk(string tag, logic [18:0] o, logic [18:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic chk_int(string tag, int o, int e);
    checks++;
    assert (o == e) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic push(int ph, bit mr);
    ph_q.push_back(ph);
    mr_q.push_back(mr);
  endtask

  // Phase plan from the instruction rules; waits only affect FETCH/MEMRD/MEMWR.
  task automatic build(logic [5:0] op, int fw, int mw);
    ph_q.delete();
    mr_q.delete();
    repeat (fw) push(P_FETCH, 0);
    push(P_FETCH, 1);
    push(P_DECODE, 1'($urandom_range(0, 1)));
    case (op)
      6'h23: begin
        push(P_MEMADR, 1'($urandom_range(0, 1)));
        repeat (mw) push(P_MEMRD, 0);
        push(P_MEMRD, 1);
        push(P_MEMWB, 1'($urandom_range(0, 1)));
      end
      6'h2B: begin
        push(P_MEMADR, 1'($urandom_range(0, 1)));
        repeat (mw) push(P_MEMWR, 0);
        push(P_MEMWR, 1);
      end
      6'h00: begin
        push(P_REX, 1'($urandom_range(0, 1)));
        push(P_ALUWB, 1'($urandom_range(0, 1)));
      end
      6'h04: push(P_BEQ, 1'($urandom_range(0, 1)));
      6'h08: begin
        push(P_AEX, 1'($urandom_range(0, 1)));
        push(P_AWB, 1'($urandom_range(0, 1)));
      end
      6'h02: push(P_JUMP, 1'($urandom_range(0, 1)));
      default: ;
    endcase
  endtask

  // Entered at posedge+1 with the DUT in FETCH; leaves it the same way.
  task automatic run_instr(string tag, logic [5:0] op, logic [5:0] f, logic z, int fw, int mw);
    int done_at = -1;
    int want;
    opcode = op;
    funct  = f;
    zero   = z;
    build(op, fw, mw);
    for (int i = 0; i < ph_q.size(); i++) begin
      mem_ready = mr_q[i];
      @(negedge clk);
      chk($sformatf("%s_c%0d", tag, i + 1), obs, expect_out(ph_q[i], z, mr_q[i], f));
      if (instr_done === 1'b1 && done_at < 0) done_at = i + 1;
      @(posedge clk);
      #1;
    end
    want = base_latency(op) + fw + ((op == 6'h23 || op == 6'h2B) ? mw : 0);
    chk_int({tag, "_latency"}, done_at, want);
  endtask

  task automatic reset_pulse(string tag);
    #2 rst_n = 1'b0;
    #1 chk({tag, "_in_reset"}, obs, expect_out(P_RESET, 0, 0, 0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_first_fetch"}, obs, expect_out(P_FETCH, zero, 0, 0));
    @(posedge clk);
    #1;
  endtask

  task automatic run_trap(string tag, logic [5:0] op, logic [5:0] f);
    opcode = op;
    funct  = f;
    mem_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_fetch"}, obs, expect_out(P_FETCH, zero, 1, f));
    @(posedge clk);
    #1 mem_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk({tag, "_decode"}, obs, expect_out(P_DECODE, zero, 0, f));
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 mem_ready = 1'($urandom_range(0, 1));
      zero = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk($sformatf("%s_trap%0d", tag, i), obs, expect_out(P_TRAP, 0, 0, f));
    end
    @(posedge clk);
    #1 reset_pulse(tag);
  endtask

  initial begin
    logic [5:0] rop, rfn;
    rst_n = 1'b0;
    opcode = 6'h00;
    funct = 6'h20;
    zero = 1'b0;
    mem_ready = 1'b0;
    #1 chk("reset_state", obs, expect_out(P_RESET, 0, 0, 0));
    @(posedge clk);
    #1 rst_n = 1'b1;

    run_instr("add", 6'h00, 6'h20, 0, 0, 0);
    run_instr("lw_stall2", 6'h23, 6'h00, 0, 0, 2);
    run_instr("beq_taken", 6'h04, 6'h11, 1, 0, 0);
    run_instr("beq_not", 6'h04, 6'h11, 0, 0, 0);
    run_instr("and", 6'h00, 6'h24, 0, 0, 0);
    run_instr("or", 6'h00, 6'h25, 0, 0, 0);
    run_instr("nor", 6'h00, 6'h27, 0, 0, 0);
    run_instr("slt", 6'h00, 6'h2A, 0, 0, 0);
    run_instr("sub", 6'h00, 6'h22, 0, 1, 0);
    run_instr("sw", 6'h2B, 6'h00, 0, 0, 0);
    run_instr("sw_stall", 6'h2B, 6'h00, 0, 2, 3);
    run_instr("addi", 6'h08, 6'h00, 0, 0, 0);
    run_instr("j", 6'h02, 6'h00, 0, 0, 0);

    run_trap("bad_op", 6'h3F, 6'h20);
    run_trap("bad_funct", 6'h00, 6'h03);

    // sw stalled in MEMWR, then reset pulled mid-cycle.
    opcode = 6'h2B;
    funct = 6'h00;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("abort_fetch", obs, expect_out(P_FETCH, zero, 1, 0));
    @(posedge clk);
    #1 mem_ready = 1'b0;
    @(negedge clk);
    chk("abort_decode", obs, expect_out(P_DECODE, zero, 0, 0));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("abort_memadr", obs, expect_out(P_MEMADR, zero, 0, 0));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("abort_memwr", obs, expect_out(P_MEMWR, zero, 0, 0));
    #1 rst_n = 1'b0;
    #1 chk_int("abort_mem_write_async", int'(mem_write), 0);
    chk("abort_in_reset", obs, expect_out(P_RESET, 0, 0, 0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("abort_first_fetch", obs, expect_out(P_FETCH, zero, 0, 0));
    @(posedge clk);
    #1;

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        rop = 6'h00;
        rfn = fns[$urandom_range(0, 5)];
      end else begin
        rop = ops[$urandom_range(0, 4)];
        rfn = 6'($urandom_range(0, 63));
      end
      run_instr($sformatf("rnd%0d_op%02h", n, rop), rop, rfn, 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
